// File: rtl/dac_pkg.sv
// Shared constants, FSM state type and code-address helpers for the DAC code loader.
package dac_pkg;

   localparam int N_LANES = 12;
   localparam int N_SLOTS = 8;
   localparam int CODE_W  = 8;
   localparam int N_CODES = 96;
   localparam int NMBR_W  = 768;
   localparam logic [6:0] BCAST_ADDR = 7'd127;

   typedef enum logic {
      IDLE,
      PEND
   } state_t;

   // Bit offset of code a inside nmbr; nmbr[offset] is the code MSB.
   function automatic int code_ofs(input logic [6:0] a);
      return CODE_W * int'(a);
   endfunction

endpackage

// File: rtl/dac_shadow_bank.sv
// 96 x 8 shadow register bank, flattened onto a 768-bit bus in nmbr order.
// Optional broadcast write to BCAST_ADDR when DAC_LOADER_BCAST_EN is defined.
module dac_shadow_bank
   import dac_pkg::*;
(
   input  logic              SCLK,
   input  logic              RESET_N,
   input  logic              wr_en,
   input  logic [6:0]        wr_addr,
   input  logic [CODE_W-1:0] wr_data,
   output logic [0:NMBR_W-1] bank
);

   logic [CODE_W-1:0] shadow [N_CODES];

   always_ff @(posedge SCLK) begin
      if (!RESET_N) begin
         for (int a = 0; a < N_CODES; a++) shadow[a] <= '0;
      end else if (wr_en) begin
`ifdef DAC_LOADER_BCAST_EN
         if (wr_addr == BCAST_ADDR) begin
            for (int a = 0; a < N_CODES; a++) shadow[a] <= wr_data;
         end else
`endif
         if (wr_addr < 7'(N_CODES)) shadow[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      bank = '0;
      for (int a = 0; a < N_CODES; a++) bank[code_ofs(7'(a)) +: CODE_W] = shadow[a];
   end

endmodule

// File: rtl/dac_code_loader.sv
// Collects DAC codes into a shadow bank and commits them to nmbr only at a frame boundary.
// Build option: DAC_LOADER_BCAST_EN enables the broadcast write address 127.
//
// state | meaning
// IDLE  | accepting write beats into the shadow bank
// PEND  | update set closed, waiting for SYNC to copy shadow into nmbr
module dac_code_loader
   import dac_pkg::*;
#(
   parameter int CODE_W  = 8,
   parameter int N_CODES = 96
) (
   input  logic                      SCLK,
   input  logic                      RESET_N,
   input  logic                      ACTIVE_N,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [6:0]                wr_addr,
   input  logic [CODE_W-1:0]         wr_data,
   input  logic                      wr_last,
   input  logic                      SYNC,
   output logic [0:CODE_W*N_CODES-1] nmbr,
   output logic                      commit_done,
   output logic                      addr_err
);

   state_t                    state, state_nxt;
   logic                      ready_q, ready_nxt;
   logic                      accept, addr_bad, commit;
   logic [0:CODE_W*N_CODES-1] bank;

   assign wr_ready = ready_q & ACTIVE_N;
   assign accept   = wr_valid & wr_ready;

`ifdef DAC_LOADER_BCAST_EN
   assign addr_bad = (wr_addr >= 7'(N_CODES)) && (wr_addr != BCAST_ADDR);
`else
   assign addr_bad = (wr_addr >= 7'(N_CODES));
`endif

   dac_shadow_bank u_bank (
      .SCLK    (SCLK),
      .RESET_N (RESET_N),
      .wr_en   (accept),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .bank    (bank)
   );

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      case (state)
         IDLE: if (accept && wr_last) state_nxt = PEND;
         PEND: if (SYNC && ACTIVE_N) begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Ready stays low through the commit cycle and returns one cycle later.
      ready_nxt = (state_nxt == IDLE) && (state == IDLE);
   end

   always_ff @(posedge SCLK) begin
      if (!RESET_N) begin
         state       <= IDLE;
         ready_q     <= 1'b0;
         nmbr        <= '0;
         commit_done <= 1'b0;
         addr_err    <= 1'b0;
      end else if (ACTIVE_N) begin
         state       <= state_nxt;
         ready_q     <= ready_nxt;
         commit_done <= commit;
         if (commit) nmbr <= bank;
         if (accept && addr_bad) addr_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dac_code_loader.sv
// Directed bench for dac_code_loader with a commit scoreboard and a shadow-bank model.
module tb_dac_code_loader;

   logic         SCLK = 1'b0;
   logic         RESET_N, ACTIVE_N, wr_valid, wr_last, SYNC;
   logic         wr_ready, commit_done, addr_err;
   logic [6:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [0:767] nmbr;

   int n_cmp = 0;
   int n_err = 0;
   int n_commit = 0;
   logic [7:0]   model_sh [96];
   logic         model_err;
   logic [0:767] exp_q [$];

   dac_code_loader dut (
      .SCLK        (SCLK),
      .RESET_N     (RESET_N),
      .ACTIVE_N    (ACTIVE_N),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_last     (wr_last),
      .SYNC        (SYNC),
      .nmbr        (nmbr),
      .commit_done (commit_done),
      .addr_err    (addr_err)
   );

   always #5 SCLK = ~SCLK;

   task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [0:767] model_flat();
      logic [0:767] v;
      for (int a = 0; a < 96; a++) v[8*a +: 8] = model_sh[a];
      return v;
   endfunction

   task automatic tick();
      logic [0:767] e;
      @(posedge SCLK);
      #1;
      if (commit_done === 1'b1) begin
         n_commit++;
         if (exp_q.size() == 0) chk("unexpected_commit", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("commit_nmbr", nmbr, e);
         end
      end
   endtask

   task automatic do_reset(input int n);
      RESET_N = 1'b0;
      repeat (n) tick();
      exp_q.delete();
      for (int a = 0; a < 96; a++) model_sh[a] = 8'h00;
      model_err = 1'b0;
      RESET_N = 1'b1;
   endtask

   task automatic write_beat(input logic [6:0] a, input logic [7:0] d,
                             input logic last, input logic s);
      int waited = 0;
      while (wr_ready !== 1'b1 && waited < 40) begin
         tick();
         waited++;
      end
      if (wr_ready !== 1'b1) chk("ready_timeout", 0, 1);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_last  = last;
      SYNC     = s;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      SYNC     = 1'b0;
      if (a < 96) model_sh[a] = d;
`ifdef DAC_LOADER_BCAST_EN
      else if (a == 7'd127) for (int i = 0; i < 96; i++) model_sh[i] = d;
`endif
      else model_err = 1'b1;
      if (last) exp_q.push_back(model_flat());
   endtask

   task automatic pulse_sync();
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
   endtask

   initial begin
      int c0;
      logic [0:767] v;
      logic [0:767] prev;
      logic [7:0]   sbyte;

      RESET_N = 1'b0; ACTIVE_N = 1'b1; wr_valid = 1'b0; wr_last = 1'b0;
      SYNC = 1'b0; wr_addr = '0; wr_data = '0;

      // 1: reset
      do_reset(3);
      chk("rst_nmbr", nmbr, 0);
      chk("rst_ready", wr_ready, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_commit_done", commit_done, 0);
      tick();
      chk("ready_after_rst", wr_ready, 1);

      // 2: single code commit
      c0 = n_commit;
      write_beat(7'd13, 8'hA5, 1'b1, 1'b0);
      chk("pend_ready", wr_ready, 0);
      tick(); tick();
      chk("pend_nmbr_hold", nmbr, 0);
      pulse_sync();
      chk("single_commit_cnt", n_commit, c0 + 1);
      chk("ready_in_commit_cycle", wr_ready, 0);
      v = '0; v[104 +: 8] = 8'hA5;
      chk("single_nmbr", nmbr, v);
      sbyte = '0;
      for (int b = 0; b < 8; b++) sbyte = {sbyte[6:0], nmbr[1*96 + 1*8 + b]};
      chk("serial_lane1_slot1", sbyte, 8'hA5);
      tick();
      chk("ready_after_commit", wr_ready, 1);
      repeat (3) tick();
      chk("single_commit_once", n_commit, c0 + 1);

      // 3: no tearing while filling the bank, SYNC pulsing every frame
      prev = nmbr;
      c0 = n_commit;
      for (int a = 0; a < 96; a++) write_beat(7'(a), 8'(a), 1'b0, (a % 17) == 16);
      chk("fill_nmbr_hold", nmbr, prev);
      write_beat(7'd95, 8'd95, 1'b1, 1'b0);
      repeat (3) tick();
      chk("fill_pend_hold", nmbr, prev);
      pulse_sync();
      chk("fill_commit_cnt", n_commit, c0 + 1);
      for (int a = 0; a < 96; a++) v[8*a +: 8] = 8'(a);
      chk("fill_index_codes", nmbr, v);
      tick();

      // 4: wr_last accepted with SYNC high commits only at the next frame
      c0 = n_commit;
      write_beat(7'd5, 8'h77, 1'b1, 1'b1);
      chk("same_cycle_no_commit", n_commit, c0);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("same_cycle_ready_low", wr_ready, 0);
      end
      chk("same_cycle_still_pend", n_commit, c0);
      pulse_sync();
      chk("same_cycle_commit_17", n_commit, c0 + 1);
      tick();

      // 5: broadcast / out-of-range 127, then bad address 100
      c0 = n_commit;
      write_beat(7'd127, 8'h3C, 1'b1, 1'b0);
      tick();
      pulse_sync();
      chk("a127_commit_cnt", n_commit, c0 + 1);
`ifdef DAC_LOADER_BCAST_EN
      for (int a = 0; a < 96; a++) v[8*a +: 8] = 8'h3C;
      chk("bcast_all_3c", nmbr, v);
      chk("bcast_no_err", addr_err, 0);
`else
      chk("a127_err", addr_err, 1);
`endif
      tick();
      prev = nmbr;
      write_beat(7'd100, 8'hFF, 1'b0, 1'b0);
      chk("bad_addr_err", addr_err, 1);
      write_beat(7'd7, 8'h11, 1'b1, 1'b0);
      pulse_sync();
      prev[56 +: 8] = 8'h11;
      chk("bad_addr_shadow_kept", nmbr, prev);
      chk("addr_err_sticky", addr_err, model_err);
      tick();

      // 6a: reset while pending
      c0 = n_commit;
      write_beat(7'd20, 8'h9A, 1'b1, 1'b0);
      do_reset(1);
      chk("rst_pend_nmbr", nmbr, 0);
      chk("rst_pend_err", addr_err, 0);
      pulse_sync();
      tick();
      chk("rst_pend_no_commit", n_commit, c0);

      // 6b: ACTIVE_N freeze across a SYNC pulse
      write_beat(7'd30, 8'h5D, 1'b1, 1'b0);
      ACTIVE_N = 1'b0;
      tick();
      chk("freeze_ready_low", wr_ready, 0);
      pulse_sync();
      tick(); tick();
      chk("freeze_no_commit", n_commit, c0);
      chk("freeze_nmbr", nmbr, 0);
      ACTIVE_N = 1'b1;
      tick();
      chk("unfreeze_wait_sync", n_commit, c0);
      pulse_sync();
      chk("unfreeze_commit", n_commit, c0 + 1);
      v = '0; v[240 +: 8] = 8'h5D;
      chk("unfreeze_nmbr", nmbr, v);
      tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
